// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, FIFO entry layout, default reset PC.
package instr_fetch_unit_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem read handshake, execute redirect, decode valid/ready.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;
  logic               id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc,instr}; head output holds its last value while empty.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    head_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Remember what decode last saw so the head is stable once drained.
  always_ff @(posedge clk) begin
    if (clr) head_q <= '0;
    else     head_q <= head;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : head_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC + single-outstanding imem request FSM feeding a prefetch FIFO.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                clr,
  instr_fetch_unit_if.master bus
);
  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic          req_q;
  logic          push, pop;
  logic [CW-1:0] count, count_after_pop;
  fetch_entry_t  push_data, head;

  assign pop             = bus.if_valid & bus.id_ready;
  assign count_after_pop = count - {{(CW-1){1'b0}}, pop};
  assign push_data       = '{pc: fetch_pc, instr: bus.imem_rdata};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    case (state)
      FETCH_IDLE:
        if (!bus.redirect && count_after_pop < DEPTH_C) state_nxt = FETCH_WAIT;
      FETCH_WAIT:
        // A redirect squashes the outstanding read; a same-cycle ack is that read.
        if (bus.redirect) begin
          state_nxt = bus.imem_ack ? FETCH_IDLE : FETCH_DROP;
        end else if (bus.imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = FETCH_IDLE;
        end
      FETCH_DROP:
        if (bus.imem_ack) state_nxt = FETCH_IDLE;
      default: state_nxt = FETCH_IDLE;
    endcase
    if (bus.redirect) fetch_pc_nxt = word_align(bus.redirect_pc);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_q    <= (state_nxt == FETCH_WAIT);
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = fetch_pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (push_data),
    .head  (head),
    .valid (bus.if_valid),
    .count (count)
  );

  assign bus.if_instr = head.instr;
  assign bus.if_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Fetch-stage bench: transaction-level queue model of buffered words, scripted and random imem/decode traffic.
module tb_instr_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RST   = 32'h0000_0000;
  localparam logic [31:0] RST2  = 32'hFFFF_FFF8;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  logic clk, clr, clr2;
  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(.RESET_PC(RST), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  instr_fetch_unit #(.RESET_PC(RST2), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .clr(clr2), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // reference model: words decode should see, and the memory's view of the request
  ent_t        q[$];
  logic [31:0] exp_fetch;
  bit          busy, live;
  int unsigned cnt;
  logic [31:0] req_addr;
  // stimulus controls
  bit          ready_in, rand_ready, redir_in, stray_in;
  logic [31:0] redir_pc_in;
  int unsigned lat_min, lat_max;
  // logs
  logic [31:0] addr_log[$];
  int          addr_t[$];
  logic [31:0] pop_log[$];
  int          cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: check outputs against the model, act as memory/decode, advance the model.
  task automatic step();
    bit ack, pop, red, rdy;
    logic [31:0] rdata;
    checks++;
    if (bus.if_valid !== (q.size() > 0)) begin
      errors++;
      $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, bus.if_valid, q.size() > 0);
    end
    if (q.size() > 0) begin
      checks++;
      if (bus.if_pc !== q[0].pc || bus.if_instr !== q[0].instr) begin
        errors++;
        $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, bus.if_pc, bus.if_instr, q[0].pc, q[0].instr);
      end
    end
    if (!busy) begin
      if (bus.imem_req === 1'b1) begin
        checks++;
        if (bus.imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, exp_fetch);
        end
        checks++;
        if (q.size() >= DEPTH) begin
          errors++;
          $display("FAIL issue_when_full cyc=%0d buffered=%0d max=%0d", cyc, q.size(), DEPTH - 1);
        end
        busy = 1; live = 1; req_addr = bus.imem_addr;
        cnt = $urandom_range(lat_max, lat_min);
        addr_log.push_back(bus.imem_addr);
        addr_t.push_back(cyc);
      end
    end else begin
      checks++;
      if (bus.imem_req !== live) begin
        errors++;
        $display("FAIL req_level cyc=%0d got=%b exp=%b", cyc, bus.imem_req, live);
      end
      if (live) begin
        checks++;
        if (bus.imem_addr !== req_addr) begin
          errors++;
          $display("FAIL addr_stable cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, req_addr);
        end
      end
    end
    ack   = (busy && cnt == 0) || (!busy && stray_in);
    rdata = busy ? mem_word(req_addr) : $urandom();
    red   = redir_in;
    rdy   = rand_ready ? ($urandom_range(1, 0) == 1) : ready_in;
    pop   = (bus.if_valid === 1'b1) && rdy;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.redirect    = red;
    bus.redirect_pc = redir_pc_in;
    bus.id_ready    = rdy;
    @(posedge clk);
    if (clr) begin
      q.delete();
      exp_fetch = RST;
      live = 0;
    end else begin
      if (pop && q.size() > 0) begin
        pop_log.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (red) begin
        q.delete();
        exp_fetch = redir_pc_in & ~32'h3;
        live = 0;
      end else if (ack && busy && live) begin
        q.push_back('{pc: req_addr, instr: rdata});
        exp_fetch = req_addr + 32'd4;
      end
    end
    if (busy) begin
      if (cnt == 0) begin busy = 0; live = 0; end
      else cnt--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_clr(input int n);
    clr = 1'b1;
    redir_in = 0; stray_in = 0; rand_ready = 0;
    for (int i = 0; i < n || busy; i++) step();
    clr = 1'b0;
    cyc = 0;
    addr_log.delete(); addr_t.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.redirect = 0; bus.redirect_pc = '0; bus.id_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete(); exp_fetch = RST; busy = 0; live = 0; cnt = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RST) begin errors++; $display("FAIL rst_addr got=%h exp=%h", bus.imem_addr, RST); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", bus.if_instr); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", bus.if_pc); end
    clr = 1'b0; cyc = 0;
    ready_in = 1; lat_min = 1; lat_max = 1;
    repeat (16) step();
    checks++;
    if (addr_log.size() < 3 || pop_log.size() < 3) begin
      errors++; $display("FAIL reset_progress got reqs=%0d pops=%0d exp>=3", addr_log.size(), pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr_log[i] !== 32'(i * 4) || pop_log[i] !== 32'(i * 4)) begin
          errors++; $display("FAIL reset_seq[%0d] got addr=%h pc=%h exp=%h", i, addr_log[i], pop_log[i], i * 4);
        end
      end
      checks++;
      if (addr_t[0] != 1) begin errors++; $display("FAIL first_req_cycle got=%0d exp=1", addr_t[0]); end
      checks++;
      if (addr_t[1] - addr_t[0] != 3 || addr_t[2] - addr_t[1] != 3) begin
        errors++; $display("FAIL req_spacing got=%0d,%0d exp=3", addr_t[1] - addr_t[0], addr_t[2] - addr_t[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_clr(2);
    ready_in = 1; lat_min = 0; lat_max = 0;
    repeat (12) step();
    checks++;
    if (addr_log.size() < 4) begin
      errors++; $display("FAIL b2b_progress got=%0d exp>=4", addr_log.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (addr_t[i] - addr_t[i-1] != 2) begin
          errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=2", i, addr_t[i] - addr_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_clr(2);
    ready_in = 0; lat_min = 1; lat_max = 1;
    repeat (20) step();
    checks++;
    if (addr_log.size() != DEPTH) begin errors++; $display("FAIL bp_reqs got=%0d exp=%0d", addr_log.size(), DEPTH); end
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle got=%b exp=0", bus.imem_req); end
    stray_in = 1; step(); stray_in = 0;
    step();
    ready_in = 1;
    repeat (20) step();
    checks++;
    if (pop_log.size() < DEPTH + 1 || addr_log.size() < DEPTH + 1) begin
      errors++; $display("FAIL bp_drain got pops=%0d reqs=%0d exp>%0d", pop_log.size(), addr_log.size(), DEPTH);
    end else begin
      for (int i = 0; i <= DEPTH; i++) begin
        checks++;
        if (pop_log[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, pop_log[i], i * 4); end
      end
      checks++;
      if (addr_log[DEPTH] !== 32'(DEPTH * 4)) begin
        errors++; $display("FAIL bp_resume got=%h exp=%h", addr_log[DEPTH], DEPTH * 4);
      end
    end
  endtask

  task automatic test_redirect_wait();
    int i, na, np;
    apply_clr(2);
    ready_in = 1; lat_min = 2; lat_max = 2;
    for (i = 0; i < 60 && !(busy && live && req_addr == 32'h10); i++) step();
    checks++;
    if (i == 60) begin errors++; $display("FAIL rw_timeout got no req to 00000010 in 60 cycles"); return; end
    redir_in = 1; redir_pc_in = 32'h0000_0103; step(); redir_in = 0;
    na = addr_log.size(); np = pop_log.size();
    repeat (20) step();
    checks++;
    if (addr_log.size() <= na || pop_log.size() <= np) begin
      errors++; $display("FAIL rw_progress got reqs=%0d pops=%0d", addr_log.size() - na, pop_log.size() - np);
    end else begin
      checks++;
      if (addr_log[na] !== 32'h100) begin errors++; $display("FAIL rw_addr got=%h exp=00000100", addr_log[na]); end
      checks++;
      if (pop_log[np] !== 32'h100) begin errors++; $display("FAIL rw_pc got=%h exp=00000100", pop_log[np]); end
    end
  endtask

  task automatic test_redirect_ack();
    int i, na, np;
    apply_clr(2);
    ready_in = 1; lat_min = 1; lat_max = 1;
    for (i = 0; i < 60 && !(busy && live && cnt == 0 && addr_log.size() >= 2); i++) step();
    checks++;
    if (i == 60) begin errors++; $display("FAIL ra_timeout got no ack slot in 60 cycles"); return; end
    redir_in = 1; redir_pc_in = 32'h0000_2002; step(); redir_in = 0;
    checks++;
    if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL ra_flush got=%b exp=0", bus.if_valid); end
    na = addr_log.size(); np = pop_log.size();
    repeat (12) step();
    checks++;
    if (addr_log.size() <= na || pop_log.size() <= np) begin
      errors++; $display("FAIL ra_progress got reqs=%0d pops=%0d", addr_log.size() - na, pop_log.size() - np);
    end else begin
      checks++;
      if (addr_log[na] !== 32'h2000) begin errors++; $display("FAIL ra_addr got=%h exp=00002000", addr_log[na]); end
      checks++;
      if (pop_log[np] !== 32'h2000) begin errors++; $display("FAIL ra_pc got=%h exp=00002000", pop_log[np]); end
    end
  endtask

  task automatic test_clr_wait();
    int i;
    apply_clr(2);
    ready_in = 1; lat_min = 3; lat_max = 3;
    for (i = 0; i < 20 && !(busy && live); i++) step();
    checks++;
    if (i == 20) begin errors++; $display("FAIL cw_timeout got no request in 20 cycles"); return; end
    clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST || bus.if_valid !== 1'b0) begin
        errors++; $display("FAIL cw_state[%0d] got req=%b addr=%h valid=%b exp 0/%h/0",
                           k, bus.imem_req, bus.imem_addr, bus.if_valid, RST);
      end
    end
    checks++;
    if (busy) begin errors++; $display("FAIL cw_ack got=pending exp=delivered during clr"); end
    clr = 1'b0;
    addr_log.delete(); pop_log.delete();
    lat_min = 1; lat_max = 1;
    repeat (10) step();
    checks++;
    if (addr_log.size() < 1 || pop_log.size() < 1 || addr_log[0] !== RST || pop_log[0] !== RST) begin
      errors++; $display("FAIL cw_restart got reqs=%0d pops=%0d exp first=%h", addr_log.size(), pop_log.size(), RST);
    end
  endtask

  task automatic test_random();
    apply_clr(2);
    rand_ready = 1; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      redir_in = ($urandom_range(99, 0) < 4);
      redir_pc_in = $urandom();
      step();
    end
    redir_in = 0; rand_ready = 0; ready_in = 1;
    checks++;
    if (pop_log.size() < 50) begin errors++; $display("FAIL rand_progress got=%0d exp>=50", pop_log.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] wa[$], wp[$];
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0000_0000;
    clr2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus2.imem_addr !== RST2 || bus2.imem_req !== 1'b0) begin
      errors++; $display("FAIL wrap_rst got addr=%h req=%b exp=%h/0", bus2.imem_addr, bus2.imem_req, RST2);
    end
    clr2 = 1'b0;
    bus2.id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus2.imem_req === 1'b1) wa.push_back(bus2.imem_addr);
      if (bus2.if_valid === 1'b1) begin
        wp.push_back(bus2.if_pc);
        checks++;
        if (bus2.if_instr !== mem_word(bus2.if_pc)) begin
          errors++; $display("FAIL wrap_instr got=%h exp=%h", bus2.if_instr, mem_word(bus2.if_pc));
        end
      end
      bus2.imem_ack   = bus2.imem_req;
      bus2.imem_rdata = mem_word(bus2.imem_addr);
      @(posedge clk);
      @(negedge clk);
    end
    bus2.imem_ack = 1'b0;
    checks++;
    if (wa.size() < 3 || wp.size() < 3) begin
      errors++; $display("FAIL wrap_progress got reqs=%0d pops=%0d exp>=3", wa.size(), wp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== exp_seq[i] || wp[i] !== exp_seq[i]) begin
          errors++; $display("FAIL wrap_seq[%0d] got addr=%h pc=%h exp=%h", i, wa[i], wp[i], exp_seq[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; clr2 = 1'b1;
    ready_in = 0; rand_ready = 0; redir_in = 0; stray_in = 0; redir_pc_in = '0;
    lat_min = 1; lat_max = 1; cyc = 0;
    bus2.imem_ack = 0; bus2.imem_rdata = '0; bus2.redirect = 0; bus2.redirect_pc = '0; bus2.id_ready = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_clr_wait();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
